// File: rtl/core_regfile_mp.sv
// -----------------------------------------------------------------------------
// core_regfile_mp
//   Parametrised multi-port integer register file with a per-register busy
//   scoreboard. Decode/issue reserves a destination (sets busy); writeback
//   writes the result and clears the reservation.
//
// Ports
//   clk_i       in   clock
//   arst_i      in   asynchronous active-high reset
//   rd_en_i     in   [NUM_RD]          per-port read enable
//   rd_addr_i   in   [NUM_RD*ADDR_W]   read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data_o   out  [NUM_RD*DATA_W]   registered read data (1-cycle latency)
//   rd_busy_o   out  [NUM_RD]          registered busy bit of the addressed register
//   wr_en_i     in   [NUM_WR]          per-port write enable
//   wr_addr_i   in   [NUM_WR*ADDR_W]   write addresses
//   wr_data_i   in   [NUM_WR*DATA_W]   write data
//   rsv_en_i    in   reserve destination register (sets busy)
//   rsv_addr_i  in   [ADDR_W]          register to reserve
//   busy_vec_o  out  [2**ADDR_W]       current busy bits, straight from flops
// -----------------------------------------------------------------------------
module core_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic [2**ADDR_W-1:0]     busy_vec_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    // True when the address names the hard-wired zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Next register and busy state. Ports are walked in ascending order so the
    // highest-index write port overwrites lower ones to the same address; the
    // reservation is applied last so it beats a same-cycle writeback clear.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // so no path leaves it unassigned and no latch is inferred.
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w] && !is_zero(wr_addr_i[w*ADDR_W +: ADDR_W])) begin
                mem_d[wr_addr_i[w*ADDR_W +: ADDR_W]]  = wr_data_i[w*DATA_W +: DATA_W];
                busy_d[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (rsv_en_i && !is_zero(rsv_addr_i)) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    // Read ports. With bypass the post-edge (next) state is sampled, which
    // forwards same-cycle write data and the post-edge busy bit. Disabled
    // ports keep their previous outputs.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en_i[p]) begin
                if (is_zero(rd_addr_i[p*ADDR_W +: ADDR_W])) begin
                    rd_data_d[p*DATA_W +: DATA_W] = '0;
                    rd_busy_d[p]                  = 1'b0;
                end else if (BYPASS != 0) begin
                    rd_data_d[p*DATA_W +: DATA_W] = mem_d[rd_addr_i[p*ADDR_W +: ADDR_W]];
                    rd_busy_d[p]                  = busy_d[rd_addr_i[p*ADDR_W +: ADDR_W]];
                end else begin
                    rd_data_d[p*DATA_W +: DATA_W] = mem_q[rd_addr_i[p*ADDR_W +: ADDR_W]];
                    rd_busy_d[p]                  = busy_q[rd_addr_i[p*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            // NOTE: the storage array is reset along with the control flops
            // because software relies on every register reading 0 after reset.
            mem_q     <= '{default: '0};
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed above, independent of statement order.
            mem_q     <= mem_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_busy_o = rd_busy_q;

    // Bit 0 is tied off when register 0 is hard-wired to zero.
    always_comb begin
        busy_vec_o = busy_q;
        if (ZERO_REG != 0) begin
            busy_vec_o[0] = 1'b0;
        end
    end

endmodule

// File: doc/core_regfile_mp.md
Name: core_regfile_mp

Overview:
- Parametrised successor to the core integer register file.
- Configurable data width, depth, read-port count and write-port count.
- Optional write-to-read bypass and hard-wired zero register.
- Per-register busy scoreboard: the issue stage reserves a destination; writeback clears the reservation. Sits between decode/issue and the execute/writeback stages.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and reservations.
- BYPASS, 1, 1 = same-cycle write data forwarded to reads of the same address.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- rd_en_i  in  NUM_RD  per-port read enable.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rd_data_o  out  NUM_RD*DATA_W  registered read data.
- rd_busy_o  out  NUM_RD  registered busy bit of the addressed register.
- wr_en_i  in  NUM_WR  per-port write enable.
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses.
- wr_data_i  in  NUM_WR*DATA_W  write data.
- rsv_en_i  in  1  reserve destination register (sets busy).
- rsv_addr_i  in  ADDR_W  register to reserve.
- busy_vec_o  out  2**ADDR_W  current busy bits; direct flop outputs.

Behaviour:
- Reset, asynchronous: all registers 0, all busy bits 0, rd_data_o 0, rd_busy_o 0. Asserting reset mid-operation discards any in-flight write or reservation in that cycle.
- Read latency is 1 cycle. With rd_en_i[p] high at edge N, rd_data_o/rd_busy_o for port p are valid after edge N.
- With rd_en_i[p] low, the port p outputs hold their previous values.
- Write takes effect at the clock edge. With BYPASS=0, a same-cycle read of that address returns the old value.
- With BYPASS=1, a same-cycle read of an address being written returns wr_data_i, and rd_busy_o reflects the post-edge busy state.
- Two write ports to the same address in one cycle: the highest-index port wins, for both storage and bypass.
- Busy update per edge:
  - wr_en_i[w] to address A clears busy[A].
  - rsv_en_i to address A sets busy[A].
  - Reserve and write to the same A in one cycle: reserve wins, busy stays 1 and data is still written.
- Reserving an already busy register leaves it busy; not an error.
- ZERO_REG=1:
  - Writes to address 0 are dropped.
  - Reservations of address 0 are ignored.
  - Reads of address 0 return 0 with busy 0, even when bypassed.
  - busy_vec_o[0] is constant 0.
- ZERO_REG=0: register 0 behaves like any other register.
- Out-of-range addresses cannot occur because depth is a power of two.
- No combinational path from any input to rd_data_o or rd_busy_o; busy_vec_o depends only on flops.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data_o = 0 and rd_busy_o = 0 one cycle after each read.
- Write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF after 1-cycle latency. Same-cycle read with BYPASS=1 -> 0xDEADBEEF. With BYPASS=0 -> old value 0.
- NUM_WR=2, both ports write r7 (0x11111111 on port 0, 0x22222222 on port 1) -> r7 reads 0x22222222.
- Reserve r3 -> busy_vec_o[3]=1 and a read of r3 shows rd_busy_o=1. Write r3 = 0x55 -> busy clears and the read returns 0x55. Reserve + write r3 in the same cycle -> busy stays 1, data = 0x55.
- ZERO_REG=1: write 0xFFFFFFFF to r0 and reserve r0 -> r0 reads 0, busy 0. Repeat with ZERO_REG=0 -> reads 0xFFFFFFFF, busy 1.
- Assert arst_i asynchronously between edges while r9 holds 0x1234 and busy -> outputs 0 immediately, r9 reads 0 and not busy after release. Deassert rd_en_i -> rd_data_o holds its last value.
